// File: rtl/control_types.sv
`default_nettype none
// ============================================================================
// Module   : control_types (package)
// Purpose  : Shared pipeline control types: operand forwarding select and
//            hazard-unit FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package control_types;

  typedef enum logic [1:0] {
    FWD_SRC_ID  = 2'd0,
    FWD_SRC_MEM = 2'd1,
    FWD_SRC_WB  = 2'd2
  } forwarding_src_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BUSY_STALL = 2'd2
  } hazard_state_t;

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
// Module   : fwd_select
// Purpose  : Operand forwarding select for one EX-stage source; MEM result
//            is younger than WB and therefore wins.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_select
  import control_types::*;
#(
  parameter int REG_IDX_W = 5
) (
  input  logic [REG_IDX_W-1:0] ex_src_idx_i,
  input  logic [REG_IDX_W-1:0] mem_reg_wr_idx_i,
  input  logic                 mem_reg_wr_en_i,
  input  logic [REG_IDX_W-1:0] wb_reg_wr_idx_i,
  input  logic                 wb_reg_wr_en_i,
  output forwarding_src_t      fwd_sel_o
);

  logic w_src_nonzero;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_src_nonzero = (ex_src_idx_i != '0);
  assign w_mem_hit     = w_src_nonzero && mem_reg_wr_en_i && (mem_reg_wr_idx_i == ex_src_idx_i);
  assign w_wb_hit      = w_src_nonzero && wb_reg_wr_en_i  && (wb_reg_wr_idx_i  == ex_src_idx_i);

  always_comb begin
    fwd_sel_o = FWD_SRC_ID;
    if (w_mem_hit) begin
      fwd_sel_o = FWD_SRC_MEM;
    end else if (w_wb_hit) begin
      fwd_sel_o = FWD_SRC_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_unit
// Purpose  : Forwarding control, multi-cycle busy scoreboard and stall FSM.
//            Optional stall counters enabled by macro HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_unit
  import control_types::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int REG_IDX_W = 5,
  parameter int NUM_REGS  = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_SRC-1:0][REG_IDX_W-1:0]   id_src_idx,
  input  logic [NUM_SRC-1:0]                  id_src_used,
  input  logic [NUM_SRC-1:0][REG_IDX_W-1:0]   ex_src_idx,
  input  logic [REG_IDX_W-1:0]                ex_reg_wr_idx,
  input  logic                                ex_reg_wr_en,
  input  logic                                ex_is_load,
  input  logic [REG_IDX_W-1:0]                mem_reg_wr_idx,
  input  logic                                mem_reg_wr_en,
  input  logic [REG_IDX_W-1:0]                wb_reg_wr_idx,
  input  logic                                wb_reg_wr_en,
  input  logic                                mc_issue_valid,
  input  logic [REG_IDX_W-1:0]                mc_issue_idx,
  input  logic                                mc_done_valid,
  input  logic [REG_IDX_W-1:0]                mc_done_idx,
  output forwarding_src_t [NUM_SRC-1:0]       fwd_ctrl,
  output logic                                stall_id,
  output logic                                flush_ex,
  output logic [31:0]                         load_stall_cnt,
  output logic [31:0]                         busy_stall_cnt
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  hazard_state_t       state_q, state_d;
  logic                w_load_hazard;
  logic                w_busy_hazard;
  logic                w_stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_select #(
      .REG_IDX_W (REG_IDX_W)
    ) u_fwd_select (
      .ex_src_idx_i     (ex_src_idx[i]),
      .mem_reg_wr_idx_i (mem_reg_wr_idx),
      .mem_reg_wr_en_i  (mem_reg_wr_en),
      .wb_reg_wr_idx_i  (wb_reg_wr_idx),
      .wb_reg_wr_en_i   (wb_reg_wr_en),
      .fwd_sel_o        (fwd_ctrl[i])
    );
  end

  // Set is applied after clear so a same-cycle issue/done on one index keeps it busy.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (mc_done_valid && (mc_done_idx == REG_IDX_W'(r))) busy_d[r] = 1'b0;
      if (mc_issue_valid && (mc_issue_idx == REG_IDX_W'(r))) busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    w_busy_hazard = 1'b0;
    w_load_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i]) begin
        for (int r = 1; r < NUM_REGS; r++) begin
          if ((id_src_idx[i] == REG_IDX_W'(r)) && busy_q[r]) w_busy_hazard = 1'b1;
        end
        if (ex_is_load && ex_reg_wr_en && (ex_reg_wr_idx != '0) &&
            (id_src_idx[i] == ex_reg_wr_idx)) begin
          w_load_hazard = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    w_stall = 1'b0;
    case (state_q)
      RUN: begin
        w_stall = w_load_hazard | w_busy_hazard;
        if (w_busy_hazard)      state_d = BUSY_STALL;
        else if (w_load_hazard) state_d = LOAD_STALL;
      end
      LOAD_STALL: begin
        w_stall = w_busy_hazard;
        state_d = w_busy_hazard ? BUSY_STALL : RUN;
      end
      BUSY_STALL: begin
        w_stall = w_busy_hazard;
        state_d = w_busy_hazard ? BUSY_STALL : RUN;
      end
      default: begin
        state_d = RUN;
        w_stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // Load hazard is combinational from inputs, so the outputs are masked during reset.
  assign stall_id = rst_n & w_stall;
  assign flush_ex = rst_n & w_stall;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] load_cnt_q;
  logic [31:0] busy_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (w_stall && !w_busy_hazard && (load_cnt_q != c_CNT_MAX)) load_cnt_q <= load_cnt_q + 32'd1;
      if (w_stall && w_busy_hazard && (busy_cnt_q != c_CNT_MAX))  busy_cnt_q <= busy_cnt_q + 32'd1;
    end
  end

  assign load_stall_cnt = load_cnt_q;
  assign busy_stall_cnt = busy_cnt_q;
`else
  assign load_stall_cnt = 32'd0;
  assign busy_stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
